// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: opcodes, NOP encoding, fetch FSM states.
package fetch_stage_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_FETCH     = 2'd0,
    FS_WAIT_SLOT = 2'd1,
    FS_DISCARD   = 2'd2
  } fetch_state_e;

  // Opcode field of an instruction word.
  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc4} buffer holding a returned word while decode stalls.
// Ports: clk/rst_n; load_i captures instr_i/pc4_i; unload_i and clear_i empty
// the entry (clear/unload win over load); valid_o/instr_o/pc4_o show the entry.
module fetch_skid_buf
  import fetch_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               unload_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc4_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc4_o
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc4_q,   pc4_d;

  // Next-state for the entry.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (clear_i || unload_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc4_d   = pc4_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage: owns the PC, drives the variable-latency
// imem req/ack port, presents one instruction at a time to decode with a
// one-entry skid so stalls never drop a word, and squashes wrong-path fetches
// on branch redirect.
// Ports: clk, rst_n; imem_req/imem_addr (out), imem_ack/imem_rdata (in);
// stall, redirect, redirect_pc (in); if_valid/if_instr/if_pc4/if_opcode (out).
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                stall,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                if_valid,
  output logic [INSTR_W-1:0]  if_instr,
  output logic [ADDR_W-1:0]   if_pc4,
  output logic [OPCODE_W-1:0] if_opcode
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q,    pc_d;
  logic               req_q,   req_d;
  logic [ADDR_W-1:0]  addr_q,  addr_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc4_q,   pc4_d;

  logic               skid_load, skid_unload, skid_clear;
  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc4;
  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  redirect_tgt;

  // pc is always the address of the current/next request, so pc+4 is both the
  // next fetch address and the pc4 of the word being returned.
  assign pc_inc       = pc_q + ADDR_W'(4);
  assign redirect_tgt = redirect_pc & ~ADDR_W'(3);

  fetch_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (skid_clear),
    .instr_i  (imem_rdata),
    .pc4_i    (pc_inc),
    .valid_o  (skid_valid),
    .instr_o  (skid_instr),
    .pc4_o    (skid_pc4)
  );

  // Next-state and output logic; redirect takes priority over stall and ack.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_d       = req_q;
    addr_d      = addr_q;
    valid_d     = valid_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;

    if (redirect) begin
      pc_d       = redirect_tgt;
      valid_d    = 1'b0;
      skid_clear = 1'b1;
      case (state_q)
        FS_FETCH: begin
          if (req_q && !imem_ack) begin
            // Outstanding request must complete at its old address.
            state_d = FS_DISCARD;
          end else begin
            req_d  = 1'b1;
            addr_d = redirect_tgt;
          end
        end
        FS_WAIT_SLOT: begin
          state_d = FS_FETCH;
          req_d   = 1'b1;
          addr_d  = redirect_tgt;
        end
        FS_DISCARD: begin
          if (req_q && imem_ack) begin
            state_d = FS_FETCH;
            addr_d  = redirect_tgt;
          end
        end
        default: state_d = FS_FETCH;
      endcase
    end else begin
      if (valid_q && !stall) begin
        valid_d = 1'b0;
      end
      case (state_q)
        FS_FETCH: begin
          if (!req_q) begin
            req_d  = 1'b1;
            addr_d = pc_q;
          end else if (imem_ack) begin
            pc_d = pc_inc;
            if (!valid_q || !stall) begin
              valid_d = 1'b1;
              instr_d = imem_rdata;
              pc4_d   = pc_inc;
              addr_d  = pc_inc;
            end else begin
              skid_load = 1'b1;
              req_d     = 1'b0;
              state_d   = FS_WAIT_SLOT;
            end
          end
        end
        FS_WAIT_SLOT: begin
          if (!stall && skid_valid) begin
            valid_d     = 1'b1;
            instr_d     = skid_instr;
            pc4_d       = skid_pc4;
            skid_unload = 1'b1;
            req_d       = 1'b1;
            addr_d      = pc_q;
            state_d     = FS_FETCH;
          end
        end
        FS_DISCARD: begin
          if (req_q && imem_ack) begin
            addr_d  = pc_q;
            state_d = FS_FETCH;
          end
        end
        default: state_d = FS_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_FETCH;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_valid  = valid_q;
  assign if_instr  = instr_q;
  assign if_pc4    = pc4_q;
  assign if_opcode = opcode_of(instr_q);

endmodule
